// File: rtl/bsg_link_downstream_rx_if.sv
// Link-side and core-side signal bundle for bsg_link_downstream_rx.
// Stats outputs exist only when BSG_LINK_RX_STATS_EN is defined.
interface bsg_link_downstream_rx_if;
    logic        io_valid_in;
    logic [7:0]  io_data_in_ch0;
    logic [7:0]  io_data_in_ch1;
    logic        io_token;
    logic [63:0] core_data_out;
    logic        core_valid_out;
    logic        core_ready_in;
    logic        overflow_err;
`ifdef BSG_LINK_RX_STATS_EN
    logic [31:0] rx_word_cnt;
    logic [15:0] tok_cnt;

    modport master (
        output io_valid_in, io_data_in_ch0, io_data_in_ch1, core_ready_in,
        input  io_token, core_data_out, core_valid_out, overflow_err, rx_word_cnt, tok_cnt
    );
    modport slave (
        input  io_valid_in, io_data_in_ch0, io_data_in_ch1, core_ready_in,
        output io_token, core_data_out, core_valid_out, overflow_err, rx_word_cnt, tok_cnt
    );
`else
    modport master (
        output io_valid_in, io_data_in_ch0, io_data_in_ch1, core_ready_in,
        input  io_token, core_data_out, core_valid_out, overflow_err
    );
    modport slave (
        input  io_valid_in, io_data_in_ch0, io_data_in_ch1, core_ready_in,
        output io_token, core_data_out, core_valid_out, overflow_err
    );
`endif
endinterface

// File: rtl/bsg_link_downstream_rx.sv
// Receive end of the BSG link: beat assembly, credit-sized word FIFO, token return.
// Optional word/token statistics counters with BSG_LINK_RX_STATS_EN.
module bsg_link_downstream_rx #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned TOKEN_BATCH = 8,
    parameter int unsigned BEATS       = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    bsg_link_downstream_rx_if.slave link
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = $clog2(BEATS);
    localparam int unsigned TW = $clog2(TOKEN_BATCH);
    localparam int unsigned PW = 16 * (BEATS - 1);

    logic [BW-1:0] beat_q, beat_d;
    logic [PW-1:0] partial_q, partial_d;
    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] tc_q, tc_d;
    logic          token_q, token_d;
    logic          ovf_q, ovf_d;

    logic [15:0] slice;
    logic [63:0] word;
    logic        last_beat, push, pop, full, accept;

    assign slice     = {link.io_data_in_ch1, link.io_data_in_ch0};
    assign word      = {slice, partial_q};
    assign last_beat = (beat_q == BW'(BEATS - 1));
    assign push      = link.io_valid_in && last_beat;
    assign pop       = (count_q != '0) && link.core_ready_in;
    assign full      = (count_q == CW'(DEPTH));
    // A pop on the same edge frees the slot, so a full FIFO still takes the word.
    assign accept    = push && (!full || pop);

    always_comb begin
        beat_d    = beat_q;
        partial_d = partial_q;
        if (link.io_valid_in) begin
            beat_d = beat_q + 1'b1;
            for (int unsigned i = 0; i < BEATS - 1; i++) begin
                if (beat_q == BW'(i)) partial_d[16*i +: 16] = slice;
            end
        end
    end

    always_comb begin
        wr_ptr_d = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q | (push && full && !pop);
    end

    always_comb begin
        tc_d    = tc_q;
        token_d = 1'b0;
        if (pop) begin
            if (tc_q == TW'(TOKEN_BATCH - 1)) begin
                tc_d    = '0;
                token_d = 1'b1;
            end else begin
                tc_d = tc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q    <= '0;
            partial_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            tc_q      <= '0;
            token_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            beat_q    <= beat_d;
            partial_q <= partial_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            tc_q      <= tc_d;
            token_q   <= token_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage is reset so the head word reads as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (accept) begin
            mem_q[wr_ptr_q] <= word;
        end
    end

    assign link.core_data_out  = mem_q[rd_ptr_q];
    assign link.core_valid_out = (count_q != '0);
    assign link.io_token       = token_q;
    assign link.overflow_err   = ovf_q;

`ifdef BSG_LINK_RX_STATS_EN
    logic [31:0] rx_word_cnt_q;
    logic [15:0] tok_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_word_cnt_q <= '0;
            tok_cnt_q     <= '0;
        end else begin
            if (accept)  rx_word_cnt_q <= rx_word_cnt_q + 1'b1;
            if (token_q) tok_cnt_q     <= tok_cnt_q + 1'b1;
        end
    end

    assign link.rx_word_cnt = rx_word_cnt_q;
    assign link.tok_cnt     = tok_cnt_q;
`endif
endmodule

// File: tb/tb_bsg_link_downstream_rx.sv
// Randomized bench for bsg_link_downstream_rx against a queue-based reference model.
module tb_bsg_link_downstream_rx;
    localparam int DEPTH = 16;
    localparam int BATCH = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   nchecks = 0;
    int   nerrors = 0;

    bsg_link_downstream_rx_if link ();

    bsg_link_downstream_rx #(
        .DEPTH      (DEPTH),
        .TOKEN_BATCH(BATCH),
        .BEATS      (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .link (link)
    );

    always #5 clk = ~clk;

    // Reference model: words in flight as a queue, beats as an array, pops as a plain count.
    logic [63:0] mq[$];
    logic [15:0] mslice[3];
    int          mbeat;
    int          mpops;
    logic        mtok;
    logic        movf;
    int unsigned m_rx;
    int unsigned m_tokc;
    int          rmode;     // 0: ready untouched, 1: ready high, 2: ready random
    int          tok_seen;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mbeat  = 0;
        mpops  = 0;
        mtok   = 1'b0;
        movf   = 1'b0;
        m_rx   = 0;
        m_tokc = 0;
    endtask

    // One clock: predict from current inputs, advance, compare at the falling edge.
    task automatic cycle();
        logic [15:0] s;
        logic [63:0] w;
        logic        pop, push, tok_n;
        if (rmode == 1) link.core_ready_in = 1'b1;
        if (rmode == 2) link.core_ready_in = 1'($urandom_range(0, 1));
        s     = {link.io_data_in_ch1, link.io_data_in_ch0};
        pop   = (mq.size() != 0) && link.core_ready_in;
        push  = link.io_valid_in && (mbeat == 3);
        tok_n = 1'b0;
        if (mtok) m_tokc++;
        if (pop) begin
            w = mq.pop_front();
            mpops++;
            if (mpops % BATCH == 0) tok_n = 1'b1;
        end
        if (push) begin
            w = {s, mslice[2], mslice[1], mslice[0]};
            if (mq.size() < DEPTH) begin
                mq.push_back(w);
                m_rx++;
            end else begin
                movf = 1'b1;
            end
        end
        if (link.io_valid_in) begin
            if (mbeat < 3) mslice[mbeat] = s;
            mbeat = (mbeat + 1) % 4;
        end
        mtok = tok_n;
        @(posedge clk);
        @(negedge clk);
        check("valid", 64'(link.core_valid_out), 64'(mq.size() != 0));
        if (mq.size() != 0) check("head", link.core_data_out, mq[0]);
        check("token", 64'(link.io_token), 64'(mtok));
        check("overflow", 64'(link.overflow_err), 64'(movf));
`ifdef BSG_LINK_RX_STATS_EN
        check("rx_word_cnt", 64'(link.rx_word_cnt), 64'(m_rx));
        check("tok_cnt", 64'(link.tok_cnt), 64'(m_tokc[15:0]));
`endif
        if (link.io_token) tok_seen++;
    endtask

    task automatic do_reset();
        link.io_valid_in = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_token", 64'(link.io_token), 64'd0);
        check("rst_valid", 64'(link.core_valid_out), 64'd0);
        check("rst_data", link.core_data_out, 64'd0);
        check("rst_ovf", 64'(link.overflow_err), 64'd0);
`ifdef BSG_LINK_RX_STATS_EN
        check("rst_rx_cnt", 64'(link.rx_word_cnt), 64'd0);
        check("rst_tok_cnt", 64'(link.tok_cnt), 64'd0);
`endif
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic beat(input logic [15:0] s);
        link.io_valid_in    = 1'b1;
        link.io_data_in_ch1 = s[15:8];
        link.io_data_in_ch0 = s[7:0];
        cycle();
        link.io_valid_in    = 1'b0;
        link.io_data_in_ch1 = 8'($urandom);
        link.io_data_in_ch0 = 8'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send_word(input logic [63:0] w, input int gap_max);
        for (int b = 0; b < 4; b++) begin
            idle($urandom_range(0, gap_max));
            beat(w[16*b +: 16]);
        end
    endtask

    task automatic drain();
        rmode = 1;
        for (int i = 0; i < 100 && mq.size() != 0; i++) cycle();
        idle(2);
        check("drained", 64'(link.core_valid_out), 64'd0);
    endtask

    initial begin
        logic [63:0] w1;
        rst_n               = 1'b0;
        link.io_valid_in    = 1'b0;
        link.io_data_in_ch0 = '0;
        link.io_data_in_ch1 = '0;
        link.core_ready_in  = 1'b0;
        rmode               = 0;
        tok_seen            = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Basic assembly, back-to-back beats.
        beat(16'h2211); beat(16'h4433); beat(16'h6655); beat(16'h8877);
        check("t1_valid", 64'(link.core_valid_out), 64'd1);
        check("t1_data", link.core_data_out, 64'h8877665544332211);
        drain();

        // Gap of three idle cycles between the 2nd and 3rd beats.
        rmode = 0;
        link.core_ready_in = 1'b0;
        beat(16'h2211); beat(16'h4433); idle(3); beat(16'h6655);
        check("t2_no_early", 64'(link.core_valid_out), 64'd0);
        beat(16'h8877);
        check("t2_data", link.core_data_out, 64'h8877665544332211);
        drain();

        // Streaming 24 words: three tokens.
        do_reset();
        rmode    = 1;
        tok_seen = 0;
        for (int i = 0; i < 24; i++) send_word({$urandom, $urandom}, 0);
        drain();
        check("t3_tokens", 64'(tok_seen), 64'd3);

        // Fill to 16, then overflow with a 17th.
        do_reset();
        rmode = 0;
        link.core_ready_in = 1'b0;
        w1 = 64'h0101_0000_0000_0001;
        for (int i = 0; i < DEPTH; i++) send_word(w1 + 64'(i), 1);
        check("t4_no_ovf", 64'(link.overflow_err), 64'd0);
        send_word(64'hDEAD_BEEF_0000_0017, 0);
        check("t4_ovf", 64'(link.overflow_err), 64'd1);
        check("t4_first", link.core_data_out, w1);
        drain();
        check("t4_ovf_sticky", 64'(link.overflow_err), 64'd1);

        // Full FIFO, last beat of the 17th word coincides with a pop.
        do_reset();
        rmode = 0;
        link.core_ready_in = 1'b0;
        for (int i = 0; i < DEPTH; i++) send_word({$urandom, $urandom}, 0);
        beat(16'hA0A1); beat(16'hA2A3); beat(16'hA4A5);
        link.core_ready_in = 1'b1;
        beat(16'hA6A7);
        link.core_ready_in = 1'b0;
        check("t5_ovf", 64'(link.overflow_err), 64'd0);
        drain();

        // Reset mid-word and mid-batch, then a fresh batch of 8.
        do_reset();
        rmode = 1;
        beat(16'h1111); beat(16'h2222);
        do_reset();
        for (int i = 0; i < 20 && mpops < 5; i++) send_word({$urandom, $urandom}, 0);
        do_reset();
        idle(2);
        tok_seen = 0;
        for (int i = 0; i < BATCH; i++) send_word({$urandom, $urandom}, 1);
        drain();
        check("t6_tokens", 64'(tok_seen), 64'd1);
`ifdef BSG_LINK_RX_STATS_EN
        check("t6_rx_cnt", 64'(link.rx_word_cnt), 64'd8);
        check("t6_tok_cnt", 64'(link.tok_cnt), 64'd1);
`endif

        // Random words, gaps and core backpressure.
        do_reset();
        rmode = 2;
        for (int i = 0; i < 60; i++) send_word({$urandom, $urandom}, 2);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule
